output_delta_seq: RTL and testbench

Output-layer error stage of the backprop path. It computes the output neuron error from the training target and the output activation. It then streams one back-propagated error term per hidden neuron, (error × output weight k), to the hidden-layer backprop stage over a valid/ready handshake. It sits directly upstream of the hidden-layer backprop logic and is started once per training sample.

---
 rtl/nn_pkg.sv | 41 ++++
 rtl/fix_mul_q44.sv | 29 ++
 rtl/output_delta_seq.sv | 127 ++++++++++++
 tb/tb_output_delta_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared fixed-point helpers and FSM encoding for the backprop stages.
//   FIX_ONE / FIX_FRAC : Q4.4 constants (1.0 and the number of fraction bits)
//   delta_state_e      : output-delta sequencer states
//   sat_fix            : signed narrowing to w bits with saturation
//   reduce_fix         : narrowing used by this stage; saturates when
//                        OUTPUT_DELTA_SAT_EN is defined, wraps otherwise
package nn_pkg;

    localparam logic [7:0] FIX_ONE  = 8'h10;
    localparam int         FIX_FRAC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } delta_state_e;

    // Clamp v into the signed w-bit range; result is sign-extended to 32 bits.
    function automatic logic signed [31:0] sat_fix(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        return v;
    endfunction

    // Narrow v to w bits (returned sign-extended so callers just keep the low w bits).
    function automatic logic signed [31:0] reduce_fix(input logic signed [31:0] v, input int w);
`ifdef OUTPUT_DELTA_SAT_EN
        return sat_fix(v, w);
`else
        logic signed [31:0] s;
        s = v <<< (32 - w);
        return s >>> (32 - w);
`endif
    endfunction

endpackage

// File: rtl/fix_mul_q44.sv
// fix_mul_q44: signed Q4.4 multiply. Full-precision product, arithmetic shift
// right by FIX_FRAC (floor), then narrowed to WIDTH with reduce_fix
// (saturating when OUTPUT_DELTA_SAT_EN is defined, wrapping otherwise).
// Ports:
//   a_i, b_i : WIDTH-bit signed operands
//   p_o      : WIDTH-bit signed result
module fix_mul_q44
    import nn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic signed [31:0]        red;
    logic                      unused_red_hi;

    assign prod    = (2*WIDTH)'($signed(a_i)) * (2*WIDTH)'($signed(b_i));
    assign shifted = prod >>> FIX_FRAC;
    assign red     = reduce_fix(32'(shifted), WIDTH);
    assign p_o     = red[WIDTH-1:0];
    // Upper bits only carry the sign extension of the narrowed value.
    assign unused_red_hi = ^red[31:WIDTH];

endmodule

// File: rtl/output_delta_seq.sv
// output_delta_seq: output-layer error stage of the backprop path.
// On start it latches target/y/weights, computes err = T - y (registered on
// err_o), then streams delta_k = reduce((err * w_k) >>> 4) for k = 0..3 over a
// valid/ready handshake, and pulses done_o for one cycle after the last term.
// Build option: define OUTPUT_DELTA_SAT_EN to saturate err and delta instead of
// wrapping them to WIDTH bits.
// Ports:
//   clk_i, rst_n_i         : clock, synchronous active-low reset
//   start_i                : begin a sample (honoured in IDLE only)
//   target_i               : 1 -> +1.0, 0 -> 0.0
//   y_i, w0_i..w3_i        : activation and output weights, signed Q4.4
//   delta_o, idx_o, valid_o: back-propagated term, its hidden index, valid
//   ready_i                : downstream accepts the presented term
//   err_o                  : registered output error
//   busy_o, done_o         : not-IDLE flag, end-of-sample pulse
module output_delta_seq
    import nn_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_HIDDEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             target_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] w0_i,
    input  logic [WIDTH-1:0] w1_i,
    input  logic [WIDTH-1:0] w2_i,
    input  logic [WIDTH-1:0] w3_i,
    output logic [WIDTH-1:0] delta_o,
    output logic [1:0]       idx_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] err_o,
    output logic             busy_o,
    output logic             done_o
);

    delta_state_e                     state_q, state_d;
    logic                             target_q, target_d;
    logic [WIDTH-1:0]                 y_q, y_d;
    logic [N_HIDDEN-1:0][WIDTH-1:0]   w_q, w_d;
    logic [WIDTH-1:0]                 err_q, err_d;
    logic [1:0]                       k_q, k_d;

    logic [N_HIDDEN-1:0][WIDTH-1:0]   w_in;
    logic [WIDTH:0]                   t_ext;
    logic signed [WIDTH:0]            err_full;
    logic signed [31:0]               err_red;
    logic                             unused_err_hi;
    logic [WIDTH-1:0]                 term;

    assign w_in = {w3_i, w2_i, w1_i, w0_i};

    // One extra bit so T - y never overflows before narrowing.
    assign t_ext         = target_q ? (WIDTH+1)'(FIX_ONE) : '0;
    assign err_full      = $signed(t_ext) - $signed({y_q[WIDTH-1], y_q});
    assign err_red       = reduce_fix(32'(err_full), WIDTH);
    assign unused_err_hi = ^err_red[31:WIDTH];

    fix_mul_q44 #(.WIDTH(WIDTH)) u_mul (
        .a_i (err_q),
        .b_i (w_q[k_q]),
        .p_o (term)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        y_d      = y_q;
        w_d      = w_q;
        err_d    = err_q;
        k_d      = k_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    target_d = target_i;
                    y_d      = y_i;
                    w_d      = w_in;
                    state_d  = ST_ERR;
                end
            end
            ST_ERR: begin
                err_d   = err_red[WIDTH-1:0];
                k_d     = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // valid_o is implied by the state, so only ready_i matters here.
                if (ready_i) begin
                    if (k_q == 2'(N_HIDDEN - 1)) state_d = ST_DONE;
                    else                         k_d     = k_q + 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            target_q <= 1'b0;
            y_q      <= '0;
            w_q      <= '0;
            err_q    <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            y_q      <= y_d;
            w_q      <= w_d;
            err_q    <= err_d;
            k_q      <= k_d;
        end
    end

    // Outputs decode registered state only; term/index are zeroed outside EMIT.
    assign valid_o = (state_q == ST_EMIT);
    assign delta_o = valid_o ? term : '0;
    assign idx_o   = valid_o ? k_q  : 2'd0;
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_output_delta_seq.sv
module tb_output_delta_seq;

    logic       clk = 1'b0;
    logic       rst_n, start, target, ready;
    logic [7:0] y, w0, w1, w2, w3;
    logic [7:0] delta, err;
    logic [1:0] idx;
    logic       valid, busy, done;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0] exp_err;
    logic [7:0] exp_d [4];
    logic [7:0] acc_d [4];
    int         exp_k;
    bit         model_on = 1'b0;

    always #5 clk = ~clk;

    output_delta_seq #(.WIDTH(8), .N_HIDDEN(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .target_i(target),
        .y_i(y), .w0_i(w0), .w1_i(w1), .w2_i(w2), .w3_i(w3),
        .delta_o(delta), .idx_o(idx), .valid_o(valid), .ready_i(ready),
        .err_o(err), .busy_o(busy), .done_o(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] reduce8(input int v);
        int r;
        r = v;
`ifdef OUTPUT_DELTA_SAT_EN
        if (r > 127)       r = 127;
        else if (r < -128) r = -128;
`endif
        return r[7:0];
    endfunction

    task automatic load_model(input bit t, input logic [7:0] yy,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        int e;
        int ws [4];
        e       = (t ? 16 : 0) - int'($signed(yy));
        exp_err = reduce8(e);
        e       = int'($signed(exp_err));
        ws[0] = int'($signed(a)); ws[1] = int'($signed(b));
        ws[2] = int'($signed(c)); ws[3] = int'($signed(d));
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = reduce8((e * ws[i]) >>> 4);
            acc_d[i] = 8'hxx;
        end
        exp_k = 0;
    endtask

    // Compare process: every presented term must be the next expected one.
    always @(negedge clk) begin
        if (model_on && valid) begin
            if (exp_k > 3) begin
                chk("extra_term", 32'(exp_k), 32'd3);
            end else begin
                chk("term_idx", 32'(idx), 32'(exp_k));
                chk("term_delta", 32'(delta), 32'(exp_d[exp_k]));
                chk("term_err", 32'(err), 32'(exp_err));
                if (ready) begin
                    acc_d[exp_k] = delta;
                    exp_k++;
                end
            end
        end
    end

    // Runs one sample. done_edge = edge index (after the start edge 0) at
    // which done_o is sampled high; -1 on timeout, -2 when reset was applied.
    task automatic run(input bit t, input logic [7:0] yy,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input int stall_idx, input int stall_n,
                       input bit busy_start, input int rst_idx,
                       output int done_edge);
        int  left;
        bit  poked;
        left  = stall_n;
        poked = 1'b0;
        load_model(t, yy, a, b, c, d);
        model_on = 1'b1;
        target = t; y = yy; w0 = a; w1 = b; w2 = c; w3 = d;
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the DUT must use its latched copies.
        target = ~t; y = ~yy; w0 = ~a; w1 = ~b; w2 = ~c; w3 = ~d;
        done_edge = -1;
        for (int n = 1; n <= 40 && done_edge == -1; n++) begin
            start = 1'b0;
            if (valid && left > 0 && int'(idx) == stall_idx) begin
                ready = 1'b0;
                left--;
            end else begin
                ready = 1'b1;
            end
            if (busy_start && !poked && valid && idx == 2'd1) begin
                start = 1'b1; y = 8'h33; w0 = 8'h44; w1 = 8'h55; w2 = 8'h66; w3 = 8'h77;
                poked = 1'b1;
            end
            if (valid && int'(idx) == rst_idx) begin
                rst_n = 1'b0;
                model_on = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_valid", 32'(valid), 32'd0);
                chk("rst_delta", 32'(delta), 32'd0);
                chk("rst_idx", 32'(idx), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                for (int m = 0; m < 6; m++) begin
                    if (done) chk("rst_no_done", 32'(done), 32'd0);
                    @(negedge clk);
                end
                chk("rst_idle_busy", 32'(busy), 32'd0);
                done_edge = -2;
            end else begin
                @(negedge clk);
                if (n == 1) chk("err_state_valid", 32'(valid), 32'd0);
                if (n == 2) begin
                    chk("first_valid", 32'(valid), 32'd1);
                    chk("err_latency", 32'(err), 32'(exp_err));
                end
                if (done) done_edge = n;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        if (done_edge == -1) chk("done_timeout", 32'd0, 32'd1);
        if (done_edge > 0) begin
            // Now in IDLE; the pulse must be gone and nothing queued.
            @(negedge clk);
            chk("done_pulse_1cyc", 32'(done), 32'd0);
            chk("idle_after_done", 32'(busy), 32'd0);
            chk("terms_seen", 32'(exp_k), 32'd4);
        end
        model_on = 1'b0;
    endtask

    int de;

    initial begin
        rst_n = 1'b0; start = 1'b0; target = 1'b0; ready = 1'b1;
        y = '0; w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_delta", 32'(delta), 32'd0);
        chk("reset_idx", 32'(idx), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sample
        run(1'b1, 8'h08, 8'h10, 8'h20, 8'hF0, 8'h00, -1, 0, 1'b0, -1, de);
        chk("basic_done_edge", 32'(de), 32'd6);
        chk("basic_err", 32'(err), 32'h08);
        chk("basic_d0", 32'(acc_d[0]), 32'h08);
        chk("basic_d1", 32'(acc_d[1]), 32'h10);
        chk("basic_d2", 32'(acc_d[2]), 32'hF8);
        chk("basic_d3", 32'(acc_d[3]), 32'h00);

        // Delta saturation
        run(1'b0, 8'h7F, 8'h7F, 8'h01, 8'h80, 8'h40, -1, 0, 1'b0, -1, de);
        chk("dsat_done_edge", 32'(de), 32'd6);
        chk("dsat_err", 32'(err), 32'h81);
`ifdef OUTPUT_DELTA_SAT_EN
        chk("dsat_d0", 32'(acc_d[0]), 32'h80);
`else
        chk("dsat_d0", 32'(acc_d[0]), 32'h0F);
`endif

        // Error saturation
        run(1'b1, 8'h80, 8'h10, 8'hF0, 8'h08, 8'h7F, -1, 0, 1'b0, -1, de);
        chk("esat_done_edge", 32'(de), 32'd6);
`ifdef OUTPUT_DELTA_SAT_EN
        chk("esat_err", 32'(err), 32'h7F);
`else
        chk("esat_err", 32'(err), 32'h90);
`endif

        // Backpressure: 3 stalled cycles at idx 1
        run(1'b1, 8'h08, 8'h10, 8'h20, 8'hF0, 8'h00, 1, 3, 1'b0, -1, de);
        chk("bp_done_edge", 32'(de), 32'd9);
        chk("bp_d1", 32'(acc_d[1]), 32'h10);

        // Start while busy is ignored
        run(1'b0, 8'h20, 8'h18, 8'hE8, 8'h7F, 8'h81, -1, 0, 1'b1, -1, de);
        chk("busy_start_done_edge", 32'(de), 32'd6);
        chk("busy_start_err", 32'(err), 32'hE0);

        // Reset during EMIT at idx 2
        run(1'b1, 8'h08, 8'h10, 8'h20, 8'hF0, 8'h00, -1, 0, 1'b0, 2, de);
        chk("rst_run_marker", 32'(de), 32'hFFFF_FFFE);

        // Normal sample after reset
        run(1'b1, 8'h08, 8'h10, 8'h20, 8'hF0, 8'h00, -1, 0, 1'b0, -1, de);
        chk("post_rst_done_edge", 32'(de), 32'd6);
        chk("post_rst_d2", 32'(acc_d[2]), 32'hF8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
